// File: rtl/dm_bus_pkg.sv
// dm_bus slave shared definitions: FSM encoding, CSR location and bit map.
// Imported by the bus RAM slave top.
package dm_bus_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_ACCESS  = 3'd1;
  localparam state_t S_RDWAIT  = 3'd2;
  localparam state_t S_ACK     = 3'd3;
  localparam state_t S_RELEASE = 3'd4;

  localparam logic [15:0] CSR_WORD_IDX = 16'hFFFF;

  localparam int DOORBELL = 0;
  localparam int ERR      = 1;

  localparam logic RW_READ = 1'b1;

endpackage

// File: rtl/bus_ram_be.sv
// Single-port 32-bit RAM with per-byte write enables and a
// registered read path of RD_LAT (1 or 2) cycles.
module bus_ram_be #(
  parameter int DEPTH     = 16384,
  parameter int RD_LAT    = 1,
  parameter     INIT_FILE = "",
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_q;

  // No reset: contents and read registers map onto block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rd_q <= mem[addr];
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [31:0] rd_p;
    always_ff @(posedge clk) begin
      rd_p <= rd_q;
    end
    assign rdata = rd_p;
  end else begin : g_lat1
    assign rdata = rd_q;
  end

endmodule

// File: rtl/dm_bus_ram_slave.sv
// dm_bus slave: byte-writable RAM window plus one doorbell/error CSR,
// four-phase request/acknowledge handshake with a level interrupt.
module dm_bus_ram_slave
  import dm_bus_pkg::*;
#(
  parameter int DEPTH_WORDS = 16384,
  parameter int RD_LAT      = 1,
  parameter bit IRQ_ON_ERR  = 1'b1,
  parameter     INIT_FILE   = ""
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [17:0] bus_address,
  input  logic        bus_bus_enable,
  input  logic [3:0]  bus_byte_enable,
  input  logic        bus_rw,
  input  logic [31:0] bus_write_data,
  output logic [31:0] bus_read_data,
  output logic        bus_acknowledge,
  output logic        bus_irq
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t      state;
  logic [17:0] cap_addr;
  logic        cap_rw;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;
  logic [1:0]  lat_cnt;
  logic        doorbell;
  logic        err;

  logic [15:0] idx;
  logic        misal;
  logic        is_ram;
  logic        is_csr;
  logic        is_err;
  logic        ram_we;
  logic [31:0] ram_rdata;
  logic [31:0] csr_word;

  assign idx    = cap_addr[17:2];
  assign misal  = |cap_addr[1:0];
  assign is_ram = !misal && (32'(idx) < DEPTH_WORDS);
  assign is_csr = !misal && (idx == CSR_WORD_IDX);
  assign is_err = !(is_ram || is_csr);
  assign ram_we = (state == S_ACCESS) && is_ram && (cap_rw != RW_READ);

  always_comb begin
    csr_word = {16'(DEPTH_WORDS), 16'h0000};
    csr_word[ERR] = err;
    csr_word[DOORBELL] = doorbell;
  end

  bus_ram_be #(
    .DEPTH     (DEPTH_WORDS),
    .RD_LAT    (RD_LAT),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk_clk),
    .we    (ram_we),
    .be    (cap_be),
    .addr  (cap_addr[AW+1:2]),
    .wdata (cap_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state           <= S_IDLE;
      cap_addr        <= '0;
      cap_rw          <= 1'b0;
      cap_be          <= '0;
      cap_wdata       <= '0;
      lat_cnt         <= '0;
      doorbell        <= 1'b0;
      err             <= 1'b0;
      bus_read_data   <= '0;
      bus_acknowledge <= 1'b0;
      bus_irq         <= 1'b0;
    end else begin
      bus_acknowledge <= 1'b0;
      bus_irq         <= doorbell | (err & IRQ_ON_ERR);
      case (state)
        S_IDLE: begin
          if (bus_bus_enable) begin
            cap_addr  <= bus_address;
            cap_rw    <= bus_rw;
            cap_be    <= bus_byte_enable;
            cap_wdata <= bus_write_data;
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          unique case (1'b1)
            is_ram: begin
              if (cap_rw == RW_READ) begin
                lat_cnt <= '0;
                state   <= S_RDWAIT;
              end else begin
                bus_read_data   <= '0;
                bus_acknowledge <= 1'b1;
                state           <= S_ACK;
              end
            end
            is_csr: begin
              bus_acknowledge <= 1'b1;
              state           <= S_ACK;
              if (cap_rw == RW_READ) begin
                bus_read_data <= csr_word;
              end else begin
                bus_read_data <= '0;
                if (cap_be[0]) begin
                  doorbell <= cap_wdata[DOORBELL];
                  if (cap_wdata[ERR]) err <= 1'b0;
                end
              end
            end
            is_err: begin
              err             <= 1'b1;
              bus_read_data   <= '0;
              bus_acknowledge <= 1'b1;
              state           <= S_ACK;
            end
          endcase
        end
        S_RDWAIT: begin
          if (lat_cnt == 2'(RD_LAT - 1)) begin
            bus_read_data   <= ram_rdata;
            bus_acknowledge <= 1'b1;
            state           <= S_ACK;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        S_ACK: state <= S_RELEASE;
        // A request still held high here is the one just served.
        S_RELEASE: begin
          if (!bus_bus_enable) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_bus_ram_slave.sv
// Bench for dm_bus_ram_slave: RD_LAT=1 and RD_LAT=2 instances share
// one stimulus stream and are checked every cycle against a model.
module tb_dm_bus_ram_slave;

  localparam int DEPTH = 16384;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [17:0] addr = '0;
  logic        en = 1'b0;
  logic [3:0]  be = '0;
  logic        rw = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata [2];
  logic        ack [2];
  logic        irq [2];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dm_bus_ram_slave #(
    .DEPTH_WORDS (DEPTH), .RD_LAT (1),
    .IRQ_ON_ERR (1'b1), .INIT_FILE ("")
  ) u_lat1 (
    .clk_clk (clk), .reset_reset_n (rst_n),
    .bus_address (addr), .bus_bus_enable (en),
    .bus_byte_enable (be), .bus_rw (rw),
    .bus_write_data (wdata), .bus_read_data (rdata[0]),
    .bus_acknowledge (ack[0]), .bus_irq (irq[0])
  );

  dm_bus_ram_slave #(
    .DEPTH_WORDS (DEPTH), .RD_LAT (2),
    .IRQ_ON_ERR (1'b1), .INIT_FILE ("")
  ) u_lat2 (
    .clk_clk (clk), .reset_reset_n (rst_n),
    .bus_address (addr), .bus_bus_enable (en),
    .bus_byte_enable (be), .bus_rw (rw),
    .bus_write_data (wdata), .bus_read_data (rdata[1]),
    .bus_acknowledge (ack[1]), .bus_irq (irq[1])
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [31:0] mem_m [int];
  bit          m_err = 1'b0;
  bit          m_db = 1'b0;
  int          due [2] = '{-1, -1};
  logic [31:0] rd_cur [2] = '{0, 0};
  logic [31:0] rd_next [2] = '{0, 0};
  bit          irq_cur = 1'b0;
  bit          irq_next = 1'b0;
  int          irq_eff [2] = '{-1, -1};
  int          ack_lat [2];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("ack%0d", d), 32'(ack[d]), 32'(cyc == due[d]));
        check($sformatf("rdata%0d", d), rdata[d],
              (due[d] >= 0 && cyc >= due[d]) ? rd_next[d] : rd_cur[d]);
        check($sformatf("irq%0d", d), 32'(irq[d]),
              32'((irq_eff[d] >= 0 && cyc >= irq_eff[d]) ? irq_next : irq_cur));
      end
    end
  end

  task automatic model(input logic [17:0] a, input logic r,
                       input logic [3:0] b, input logic [31:0] w,
                       output logic [31:0] res, output bit ram_rd);
    int idx;
    idx = int'(a[17:2]);
    res = '0;
    ram_rd = 1'b0;
    if (a[1:0] != 2'b00 || (idx >= DEPTH && idx != 16'hFFFF)) begin
      m_err = 1'b1;
    end else if (idx == 16'hFFFF) begin
      if (r) res = {16'(DEPTH), 14'b0, m_err, m_db};
      else if (b[0]) begin
        m_db = w[0];
        if (w[1]) m_err = 1'b0;
      end
    end else if (r) begin
      ram_rd = 1'b1;
      res = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (b[i]) mem_m[idx][8*i +: 8] = w[8*i +: 8];
    end
  endtask

  task automatic roll();
    for (int d = 0; d < 2; d++)
      if (due[d] >= 0) rd_cur[d] = rd_next[d];
    if (irq_eff[0] >= 0) irq_cur = irq_next;
  endtask

  task automatic txn(input logic [17:0] a, input logic r,
                     input logic [3:0] b, input logic [31:0] w,
                     input int hold, input bit drop1);
    logic [31:0] res;
    bit ram_rd;
    bit seen [2];
    int c;
    int n;
    @(posedge clk); #1;
    roll();
    c = cyc;
    model(a, r, b, w, res, ram_rd);
    for (int d = 0; d < 2; d++) begin
      due[d] = c + 2 + (ram_rd ? d + 1 : 0);
      rd_next[d] = res;
      irq_eff[d] = due[d] + 1;
    end
    irq_next = m_db | m_err;
    addr = a; rw = r; be = b; wdata = w; en = 1'b1;
    if (drop1) begin
      @(posedge clk); #1;
      en = 1'b0;
    end
    seen = '{1'b0, 1'b0};
    ack_lat = '{-1, -1};
    n = 0;
    while (!(seen[0] && seen[1]) && n < 20) begin
      @(negedge clk);
      n++;
      for (int d = 0; d < 2; d++)
        if (ack[d] && !seen[d]) begin
          seen[d] = 1'b1;
          ack_lat[d] = cyc - c;
        end
    end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (!seen[d]) begin
        errors++;
        $display("FAIL ack_timeout%0d: got none want ack within 20 cycles", d);
      end
    end
    repeat (hold) @(posedge clk);
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic lit(input string name, input logic [31:0] v0,
                     input logic [31:0] v1, input logic [31:0] exp0,
                     input logic [31:0] exp1);
    check({name, "_l1"}, v0, exp0);
    check({name, "_l2"}, v1, exp1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    lit("rst_ack", 32'(ack[0]), 32'(ack[1]), 0, 0);
    lit("rst_rdata", rdata[0], rdata[1], 0, 0);
    lit("rst_irq", 32'(irq[0]), 32'(irq[1]), 0, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    txn(18'h00010, 1'b0, 4'hF, 32'hDEADBEEF, 0, 1'b0);
    lit("wr_lat", ack_lat[0], ack_lat[1], 2, 2);
    txn(18'h00010, 1'b1, 4'h0, 32'h0, 0, 1'b0);
    lit("rd_lat", ack_lat[0], ack_lat[1], 3, 4);
    lit("rd1", rdata[0], rdata[1], 32'hDEADBEEF, 32'hDEADBEEF);

    txn(18'h00010, 1'b0, 4'b0101, 32'h11223344, 0, 1'b0);
    txn(18'h00010, 1'b1, 4'h0, 32'h0, 0, 1'b0);
    lit("rd2", rdata[0], rdata[1], 32'hDE22BE44, 32'hDE22BE44);
    txn(18'h00010, 1'b0, 4'h0, 32'hFFFFFFFF, 0, 1'b0);
    txn(18'h00010, 1'b1, 4'h0, 32'h0, 0, 1'b0);
    lit("be0_noop", rdata[0], rdata[1], 32'hDE22BE44, 32'hDE22BE44);

    txn(18'h00012, 1'b1, 4'h0, 32'h0, 0, 1'b0);
    lit("misal_rd", rdata[0], rdata[1], 0, 0);
    txn(18'h00010, 1'b1, 4'h0, 32'h0, 0, 1'b0);
    txn(18'(DEPTH * 4), 1'b1, 4'h0, 32'h0, 0, 1'b0);
    lit("oob_rd", rdata[0], rdata[1], 0, 0);
    txn(18'h3FFFC, 1'b1, 4'h0, 32'h0, 0, 1'b0);
    lit("csr_err", rdata[0], rdata[1], 32'h40000002, 32'h40000002);
    lit("irq_err", 32'(irq[0]), 32'(irq[1]), 1, 1);
    txn(18'h3FFFC, 1'b0, 4'h1, 32'h2, 0, 1'b0);
    lit("irq_w1c", 32'(irq[0]), 32'(irq[1]), 0, 0);

    txn(18'h3FFFC, 1'b0, 4'h1, 32'h1, 0, 1'b0);
    lit("irq_db", 32'(irq[0]), 32'(irq[1]), 1, 1);
    txn(18'h3FFFC, 1'b1, 4'h0, 32'h0, 0, 1'b0);
    lit("csr_db", rdata[0], rdata[1], 32'h40000001, 32'h40000001);
    txn(18'h3FFFC, 1'b0, 4'hE, 32'h0, 0, 1'b0);
    txn(18'h3FFFC, 1'b0, 4'h1, 32'h0, 0, 1'b0);
    lit("irq_clr", 32'(irq[0]), 32'(irq[1]), 0, 0);

    txn(18'h00020, 1'b0, 4'hF, 32'hCAFEF00D, 10, 1'b0);
    txn(18'h00024, 1'b0, 4'hF, 32'h12345678, 0, 1'b1);
    txn(18'h00024, 1'b1, 4'h0, 32'h0, 0, 1'b0);
    lit("drop_wr", rdata[0], rdata[1], 32'h12345678, 32'h12345678);
    txn(18'h00020, 1'b1, 4'h0, 32'h0, 0, 1'b0);
    lit("hold_wr", rdata[0], rdata[1], 32'hCAFEF00D, 32'hCAFEF00D);

    txn(18'h3FFFC, 1'b0, 4'h1, 32'h1, 0, 1'b0);
    @(posedge clk); #1;
    roll();
    addr = 18'h00024; rw = 1'b1; be = 4'h0; en = 1'b1;
    due = '{-1, -1};
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    m_err = 1'b0; m_db = 1'b0;
    rd_cur = '{0, 0}; irq_cur = 1'b0; irq_eff = '{-1, -1};
    #1;
    lit("arst_ack", 32'(ack[0]), 32'(ack[1]), 0, 0);
    lit("arst_rdata", rdata[0], rdata[1], 0, 0);
    lit("arst_irq", 32'(irq[0]), 32'(irq[1]), 0, 0);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    txn(18'h00020, 1'b1, 4'h0, 32'h0, 0, 1'b0);
    lit("post_rst", rdata[0], rdata[1], 32'hCAFEF00D, 32'hCAFEF00D);

    repeat (3) @(posedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
